// File: rtl/cam_pkg.sv
// cam_pkg: shared types, default geometry and pixel conversion for the
// camera capture front end.
//   cap_state_t    capture FSM state (IDLE, SYNC, ACTIVE)
//   CAM_H_RES      default pixels per line
//   CAM_V_RES      default lines per frame
//   rgb565_to_444  folds an RGB565 byte pair into a 12-bit RGB444 pixel
package cam_pkg;

    localparam int CAM_H_RES = 320;
    localparam int CAM_V_RES = 240;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } cap_state_t;

    // The camera sends {R5,G6[5:3]} first, then {G6[2:0],B5}. Keep the top
    // four bits of each colour component.
    function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi,
                                                  input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_capture_rgb444_sync_edge.sv
// sync_edge: two-flop synchroniser for one asynchronous level, plus a
// previous-value flop used for edge detection.
//   clk      system clock
//   reset    synchronous, active-high; clears all three flops
//   async_i  raw asynchronous input
//   level_o  synchronised level (second flop)
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
//   fall_o   one-cycle pulse on a synchronised 1->0 transition
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// cam_capture_rgb444: brings an OV7670-style parallel camera bus into the
// clk domain, packs RGB565 byte pairs into RGB444 pixels and writes them
// into a frame buffer, one single-cycle write per pixel.
//   clk, reset        system clock (>= 4x pclk); synchronous active-high reset
//   enable            capture armed (ignored once a frame is ACTIVE)
//   cam_pclk/vsync/href/data   raw asynchronous camera bus
//   wr_en/wr_addr/wr_data      frame-buffer write port, data = {R4,G4,B4}
//   frame_done        one-cycle pulse when a captured frame ends
//   frame_err         geometry status of the last completed frame
//   busy              high while a frame is being captured
module cam_capture_rgb444
    import cam_pkg::*;
#(
    parameter int H_RES  = CAM_H_RES,
    parameter int V_RES  = CAM_V_RES,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    // Counters are one value wider than needed so that overrun (x > H_RES,
    // y > V_RES) is representable; they saturate at all-ones.
    localparam int X_W = $clog2(H_RES + 2);
    localparam int Y_W = $clog2(V_RES + 2);
    localparam logic [X_W-1:0] H_LIM = X_W'(H_RES);
    localparam logic [Y_W-1:0] V_LIM = Y_W'(V_RES);

    logic pclk_lvl, pclk_rise, pclk_fall;
    logic href_lvl, href_rise, href_fall;
    logic vs_lvl,   vs_rise,   vs_fall;

    sync_edge u_sync_pclk (.clk(clk), .reset(reset), .async_i(cam_pclk),
                           .level_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall));
    sync_edge u_sync_href (.clk(clk), .reset(reset), .async_i(cam_href),
                           .level_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall));
    sync_edge u_sync_vs   (.clk(clk), .reset(reset), .async_i(cam_vsync),
                           .level_o(vs_lvl),   .rise_o(vs_rise),   .fall_o(vs_fall));

    // Data takes the same two-flop path as pclk so the byte seen on a
    // synced pclk rise is the one the camera presented at that raw edge.
    logic [7:0] data_s1_q, data_s2_q;

    cap_state_t        state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_s1_q    <= '0;
            data_s2_q    <= '0;
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_s1_q    <= cam_data;
            data_s2_q    <= data_s1_q;
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = SYNC;
            end
            SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Frame end wins over any line activity in this cycle; a
                    // partial line does not count towards y.
                    frame_done_d = 1'b1;
                    frame_err_d  = err_q | (y_q != V_LIM);
                    state_d      = enable ? SYNC : IDLE;
                end else begin
                    if (pclk_rise && href_lvl) begin
                        if (!phase_q) begin
                            hi_d    = data_s2_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (x_q < H_LIM && y_q < V_LIM) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = rgb565_to_444(hi_q, data_s2_q);
                                addr_d    = addr_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                            if (x_q != '1) x_d = x_q + 1'b1;
                        end
                    end
                    // Line end sees the post-sample x/phase, so a sample in
                    // the same cycle is accounted for first.
                    if (href_fall) begin
                        if (x_d != H_LIM || phase_d) err_d = 1'b1;
                        x_d     = '0;
                        phase_d = 1'b0;
                        if (y_q != '1) y_d = y_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Bench for cam_capture_rgb444 with a 4x2 frame geometry. Camera frames are
// described as byte lists plus per-line byte counts; a reference model turns
// that description into the expected frame-buffer writes and error flag.
module tb_cam_capture_rgb444;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 17;
  localparam logic [7:0] PAT [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0,
                                     8'h00, 8'h1F, 8'hFF, 8'hFF};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cam_pclk = 1'b0;
  logic cam_vsync = 1'b1;
  logic cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0] wr_data;
  logic frame_done;
  logic frame_err;
  logic busy;

  cam_capture_rgb444 #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- frame description and scoreboard ----------------
  logic [7:0]    byte_q[$];
  int            len_q[$];
  logic [AW-1:0] exp_addr[$];
  logic [11:0]   exp_data[$];
  logic          exp_err;
  logic [AW-1:0] got_addr[$];
  logic [11:0]   got_data[$];
  int            fd_cnt;
  logic          busy_seen;
  logic [32:0]   snap;
  int            n_pass = 0;
  int            n_total = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    fd_cnt = 0;
    busy_seen = 1'b0;
  endtask

  task automatic new_frame();
    byte_q.delete();
    len_q.delete();
  endtask

  task automatic add_line(input int n);
    for (int i = 0; i < n; i++) byte_q.push_back(PAT[i % 8]);
    len_q.push_back(n);
  endtask

  task automatic add_rand_line(input int n);
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    len_q.push_back(n);
  endtask

  // Reference model: pixels are byte pairs within a line; a pixel lands in
  // the buffer only if its column and row are inside the frame, at the next
  // free address. Colour is reduced from 5/6/5 to 4/4/4 by dropping LSBs.
  task automatic model_frame();
    int idx, npix, r5, g6, b5;
    logic [7:0] hi, lo;
    logic [AW-1:0] a;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 1'b0;
    idx = 0;
    a = '0;
    for (int l = 0; l < len_q.size(); l++) begin
      npix = len_q[l] / 2;
      if ((len_q[l] % 2) != 0 || npix != H) exp_err = 1'b1;
      for (int p = 0; p < npix; p++) begin
        hi = byte_q[idx + 2 * p];
        lo = byte_q[idx + 2 * p + 1];
        if (p < H && l < V) begin
          r5 = int'(hi) / 8;
          g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
          b5 = int'(lo) % 32;
          exp_addr.push_back(a);
          exp_data.push_back(12'((r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2)));
          a = a + 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
      idx += len_q[l];
    end
    if (len_q.size() != V) exp_err = 1'b1;
  endtask

  // ---------------- drivers ----------------
  // One camera pixel clock spans 4 system clocks; data/href change while
  // pclk is low.
  task automatic pclk_cycle(input logic [7:0] d, input logic h);
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_data = d;
    cam_href = h;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    @(negedge clk);
  endtask

  // rst_line: line on which reset is pulsed after two bytes (-1 = never).
  // en_line: line at whose start enable is set to en_val (-1 = never).
  task automatic drive_frame(input int rst_line, input int en_line, input logic en_val);
    int idx;
    cam_vsync = 1'b1;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    cam_vsync = 1'b0;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    idx = 0;
    for (int l = 0; l < len_q.size(); l++) begin
      if (l == en_line) enable = en_val;
      for (int b = 0; b < len_q[l]; b++) begin
        if (l == rst_line && b == 2) begin
          @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          snap = {wr_en, wr_addr, wr_data, frame_done, frame_err, busy};
          reset = 1'b0;
        end
        pclk_cycle(byte_q[idx], 1'b1);
        idx++;
      end
      repeat (2) pclk_cycle(8'h00, 1'b0);
    end
    cam_vsync = 1'b1;
    repeat (4) pclk_cycle(8'h00, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({wr_en, wr_addr, wr_data, frame_done, frame_err, busy} !== 33'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {wr_en, wr_addr, wr_data, frame_done, frame_err, busy});
    else n_pass++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if ({wr_en, frame_done, busy} !== 3'b000)
      $display("FAIL post_reset_idle: got %b expected 000", {wr_en, frame_done, busy});
    else n_pass++;
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    new_frame(); add_line(8); add_line(8);
    clear_mon();
    drive_frame(-1, -1, 1'b0);
    n_total++;
    if (got_addr.size() !== 0) $display("FAIL enoff_writes: got %0d expected 0", got_addr.size());
    else n_pass++;
    n_total++;
    if ({fd_cnt != 0, busy_seen} !== 2'b00)
      $display("FAIL enoff_done_busy: got fd=%0d busy_seen=%b expected 0/0", fd_cnt, busy_seen);
    else n_pass++;
  endtask

  // Nominal, short, long and odd-byte first lines; second line is nominal.
  task automatic test_geometry();
    int cfg[4] = '{8, 6, 10, 9};
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      new_frame(); add_line(cfg[c]); add_line(8);
      model_frame();
      clear_mon();
      drive_frame(-1, -1, 1'b0);
      n_total++;
      if (got_addr.size() !== exp_addr.size())
        $display("FAIL geom%0d_count: got %0d expected %0d", c, got_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
        n_total++;
        if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]})
          $display("FAIL geom%0d_write%0d: got %0h/%03h expected %0h/%03h", c, i,
                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_total++;
      if (fd_cnt !== 1) $display("FAIL geom%0d_done: got %0d expected 1", c, fd_cnt);
      else n_pass++;
      n_total++;
      if (frame_err !== exp_err) $display("FAIL geom%0d_err: got %b expected %b", c, frame_err, exp_err);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1;
    new_frame(); add_line(8); add_line(8);
    model_frame();
    clear_mon();
    drive_frame(1, -1, 1'b0);
    n_total++;
    if (snap !== 33'd0) $display("FAIL rstmid_outputs: got %h expected 0", snap);
    else n_pass++;
    n_total++;
    if (got_addr.size() !== H) $display("FAIL rstmid_count: got %0d expected %0d", got_addr.size(), H);
    else n_pass++;
    for (int i = 0; i < got_addr.size() && i < H; i++) begin
      n_total++;
      if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL rstmid_write%0d: got %0h/%03h expected %0h/%03h", i,
                 got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_total++;
    if (fd_cnt !== 0) $display("FAIL rstmid_done: got %0d expected 0", fd_cnt);
    else n_pass++;
    clear_mon();
    drive_frame(-1, -1, 1'b0);
    n_total++;
    if (got_addr.size() !== exp_addr.size())
      $display("FAIL rstnext_count: got %0d expected %0d", got_addr.size(), exp_addr.size());
    else n_pass++;
    n_total++;
    if (got_addr.size() > 0 && got_addr[0] !== '0) $display("FAIL rstnext_addr0: got %0h expected 0", got_addr[0]);
    else n_pass++;
    n_total++;
    if ({fd_cnt == 1, frame_err} !== {1'b1, exp_err})
      $display("FAIL rstnext_done_err: got fd=%0d err=%b expected 1/%b", fd_cnt, frame_err, exp_err);
    else n_pass++;
  endtask

  task automatic test_enable_mid_frame();
    enable = 1'b0;
    repeat (4) @(negedge clk);
    new_frame(); add_line(8); add_line(8);
    model_frame();
    clear_mon();
    drive_frame(-1, 1, 1'b1);
    n_total++;
    if ({got_addr.size() == 0, fd_cnt == 0} !== 2'b11)
      $display("FAIL enmid_quiet: got writes=%0d fd=%0d expected 0/0", got_addr.size(), fd_cnt);
    else n_pass++;
    clear_mon();
    drive_frame(-1, -1, 1'b0);
    n_total++;
    if (got_addr.size() !== exp_addr.size())
      $display("FAIL enmid_next_count: got %0d expected %0d", got_addr.size(), exp_addr.size());
    else n_pass++;
    n_total++;
    if (fd_cnt !== 1) $display("FAIL enmid_next_done: got %0d expected 1", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    new_frame(); add_line(8); add_line(8);
    model_frame();
    clear_mon();
    drive_frame(-1, 1, 1'b0);
    n_total++;
    if (got_addr.size() !== exp_addr.size())
      $display("FAIL endrop_count: got %0d expected %0d", got_addr.size(), exp_addr.size());
    else n_pass++;
    n_total++;
    if ({fd_cnt == 1, frame_err} !== {1'b1, exp_err})
      $display("FAIL endrop_done_err: got fd=%0d err=%b expected 1/%b", fd_cnt, frame_err, exp_err);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL endrop_busy: got %b expected 0", busy);
    else n_pass++;
    clear_mon();
    drive_frame(-1, -1, 1'b0);
    n_total++;
    if ({got_addr.size() == 0, fd_cnt == 0} !== 2'b11)
      $display("FAIL endrop_next_quiet: got writes=%0d fd=%0d expected 0/0", got_addr.size(), fd_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int nl;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    for (int f = 0; f < 8; f++) begin
      new_frame();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) add_rand_line($urandom_range(6, 10));
      model_frame();
      clear_mon();
      drive_frame(-1, -1, 1'b0);
      n_total++;
      if (got_addr.size() !== exp_addr.size())
        $display("FAIL rnd%0d_count: got %0d expected %0d", f, got_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
        n_total++;
        if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]})
          $display("FAIL rnd%0d_write%0d: got %0h/%03h expected %0h/%03h", f, i,
                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_total++;
      if ({fd_cnt == 1, frame_err} !== {1'b1, exp_err})
        $display("FAIL rnd%0d_done_err: got fd=%0d err=%b expected 1/%b", f, fd_cnt, frame_err, exp_err);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fd_cnt = 0;
    busy_seen = 1'b0;
    snap = '0;
    test_reset();
    test_enable_off();
    test_geometry();
    test_reset_mid_frame();
    test_enable_mid_frame();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
